// File: rtl/algo_nror1w_rdchk.sv
// Read-data checker for the N-read-or-1-write memory family: a shadow memory plus a
// per-port latency pipeline that checks every response, command mix and refresh cadence.
module algo_nror1w_rdchk #(
   parameter int NUMRDPT = 4,
   parameter int WIDTH   = 64,
   parameter int NUMADDR = 8192,
   parameter int BITADDR = 13,
   parameter int DELAY   = 2,
   parameter int REFRESH = 1,
   parameter int REFFREQ = 6,
   parameter int ERRCNTW = 16
) (
   input  logic                                               i_clk,
   input  logic                                               i_rst,
   input  logic                                               i_ready,
   input  logic                                               i_refr,
   input  logic                                               i_write,
   input  logic [BITADDR-1:0]                                 i_wr_adr,
   input  logic [WIDTH-1:0]                                   i_din,
   input  logic [NUMRDPT-1:0]                                 i_read,
   input  logic [NUMRDPT*BITADDR-1:0]                         i_rd_adr,
   input  logic [NUMRDPT-1:0]                                 i_rd_vld,
   input  logic [NUMRDPT*WIDTH-1:0]                           i_rd_dout,
   input  logic [NUMRDPT-1:0]                                 i_rd_serr,
   input  logic [NUMRDPT-1:0]                                 i_rd_derr,
   output logic                                               o_err_any,
   output logic [NUMRDPT-1:0]                                 o_data_err,
   output logic [NUMRDPT-1:0]                                 o_vld_err,
   output logic                                               o_cmd_err,
   output logic                                               o_refr_err,
   output logic [ERRCNTW-1:0]                                 o_derr_cnt,
   output logic [ERRCNTW-1:0]                                 o_err_cnt,
   output logic [((NUMRDPT > 1) ? $clog2(NUMRDPT) : 1)-1:0]   o_first_port,
   output logic [BITADDR-1:0]                                 o_first_adr
);

   localparam int PW = (NUMRDPT > 1) ? $clog2(NUMRDPT) : 1;
   localparam int RW = (REFFREQ > 0) ? $clog2(REFFREQ + 1) : 1;

   logic [WIDTH-1:0]                                r_mem [NUMADDR];
   logic [NUMADDR-1:0]                              r_known;
   logic [DELAY-1:0][NUMRDPT-1:0]                   r_pl_iss;
   logic [DELAY-1:0][NUMRDPT-1:0]                   r_pl_knw;
   logic [DELAY-1:0][NUMRDPT-1:0][WIDTH-1:0]        r_pl_exp;
   logic [DELAY-1:0][NUMRDPT-1:0][BITADDR-1:0]      r_pl_adr;
   logic [RW-1:0]                                   r_ref_cnt;
   logic                                            r_err_any;
   logic                                            r_refr_err;
   logic [ERRCNTW-1:0]                              r_err_cnt;
   logic [ERRCNTW-1:0]                              r_derr_cnt;
   logic [PW-1:0]                                   r_first_port;
   logic [BITADDR-1:0]                              r_first_adr;

   logic [NUMRDPT-1:0]                              w_iss;
   logic [NUMRDPT-1:0]                              w_knw;
   logic [NUMRDPT-1:0][WIDTH-1:0]                   w_exp;
   logic [NUMRDPT-1:0][BITADDR-1:0]                 w_adr;
   logic [NUMRDPT-1:0][BITADDR-1:0]                 w_iss_adr;
   logic [NUMRDPT-1:0]                              w_data_err;
   logic [NUMRDPT-1:0]                              w_vld_err;
   logic [NUMRDPT-1:0]                              w_perr;
   logic [NUMRDPT-1:0]                              w_derr;
   logic                                            w_any_cmd;
   logic                                            w_cmd_err;
   logic                                            w_refr_viol;
   logic [ERRCNTW:0]                                w_err_sum;
   logic [ERRCNTW:0]                                w_derr_sum;
   logic [PW-1:0]                                   w_low_port;
   logic [BITADDR-1:0]                              w_low_adr;
   logic                                            w_unused;

   // Corrected responses are compared like clean ones, so the serr flag carries no check.
   assign w_unused = ^i_rd_serr;

   // Shadow reads happen before this cycle's write lands, so a same-cycle read sees old data.
   always_comb begin
      w_adr     = i_rd_adr;
      w_iss     = '0;
      w_knw     = '0;
      w_exp     = '0;
      w_iss_adr = '0;
      for (int p = 0; p < NUMRDPT; p++) begin
         w_iss[p] = i_read[p] & i_ready;
         w_knw[p] = r_known[w_adr[p]];
         w_exp[p] = r_mem[w_adr[p]];
         w_iss_adr[p] = w_iss[p] ? w_adr[p] : '0;
      end
   end

   always_comb begin
      w_any_cmd  = i_write | (|i_read);
      w_cmd_err  = !i_rst & ((i_write & (|i_read)) | (w_any_cmd & !i_ready) |
                             ((REFRESH != 0) & i_refr & w_any_cmd));
      w_data_err = '0;
      w_vld_err  = '0;
      w_derr     = '0;
      for (int p = 0; p < NUMRDPT; p++) begin
         w_vld_err[p]  = !i_rst & (r_pl_iss[DELAY-1][p] ^ i_rd_vld[p]);
         w_data_err[p] = !i_rst & r_pl_iss[DELAY-1][p] & i_rd_vld[p] & r_pl_knw[DELAY-1][p] &
                         !i_rd_derr[p] & (i_rd_dout[p*WIDTH +: WIDTH] != r_pl_exp[DELAY-1][p]);
         w_derr[p]     = i_rd_vld[p] & i_rd_derr[p];
      end
      w_perr      = w_data_err | w_vld_err;
      w_refr_viol = (REFRESH != 0) && (r_ref_cnt == RW'(REFFREQ)) && !i_refr && !i_rst;
      w_err_sum   = {1'b0, r_err_cnt} + (ERRCNTW+1)'($countones(w_perr));
      w_derr_sum  = {1'b0, r_derr_cnt} + (ERRCNTW+1)'($countones(w_derr));
      w_low_port  = '0;
      w_low_adr   = '0;
      for (int p = NUMRDPT - 1; p >= 0; p--) begin
         if (w_perr[p]) begin
            w_low_port = PW'(p);
            w_low_adr  = r_pl_adr[DELAY-1][p];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_ready && i_write) r_mem[i_wr_adr] <= i_din;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_known      <= '0;
         r_pl_iss     <= '0;
         r_pl_knw     <= '0;
         r_pl_exp     <= '0;
         r_pl_adr     <= '0;
         r_ref_cnt    <= '0;
         r_err_any    <= 1'b0;
         r_refr_err   <= 1'b0;
         r_err_cnt    <= '0;
         r_derr_cnt   <= '0;
         r_first_port <= '0;
         r_first_adr  <= '0;
      end else begin
         if (i_ready && i_write) r_known[i_wr_adr] <= 1'b1;
         r_pl_iss[0] <= w_iss;
         r_pl_knw[0] <= w_knw;
         r_pl_exp[0] <= w_exp;
         r_pl_adr[0] <= w_iss_adr;
         for (int k = 1; k < DELAY; k++) begin
            r_pl_iss[k] <= r_pl_iss[k-1];
            r_pl_knw[k] <= r_pl_knw[k-1];
            r_pl_exp[k] <= r_pl_exp[k-1];
            r_pl_adr[k] <= r_pl_adr[k-1];
         end
         if (i_refr) r_ref_cnt <= '0;
         else if (i_ready && (r_ref_cnt != RW'(REFFREQ))) r_ref_cnt <= r_ref_cnt + 1'b1;
         if (w_refr_viol) r_refr_err <= 1'b1;
         if ((|w_perr) || w_cmd_err || w_refr_viol) r_err_any <= 1'b1;
         r_err_cnt  <= w_err_sum[ERRCNTW]  ? '1 : w_err_sum[ERRCNTW-1:0];
         r_derr_cnt <= w_derr_sum[ERRCNTW] ? '1 : w_derr_sum[ERRCNTW-1:0];
         if (!r_err_any && (|w_perr)) begin
            r_first_port <= w_low_port;
            r_first_adr  <= w_low_adr;
         end
      end
   end

   assign o_err_any    = r_err_any;
   assign o_data_err   = w_data_err;
   assign o_vld_err    = w_vld_err;
   assign o_cmd_err    = w_cmd_err;
   assign o_refr_err   = r_refr_err;
   assign o_derr_cnt   = r_derr_cnt;
   assign o_err_cnt    = r_err_cnt;
   assign o_first_port = r_first_port;
   assign o_first_adr  = r_first_adr;

endmodule

// File: tb/tb_algo_nror1w_rdchk.sv
// Bench for algo_nror1w_rdchk: a time-stamped read queue and associative shadow model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_algo_nror1w_rdchk;
   localparam int NP = 4, W = 64, BA = 13, DL = 2, RF = 6, CW = 16;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0, rst = 1'b1, ready = 1'b0, refr = 1'b0, write = 1'b0;
   logic [BA-1:0] wr_adr = '0;
   logic [W-1:0] din = '0;
   logic [NP-1:0] read = '0, rd_vld = '0, rd_serr = '0, rd_derr = '0;
   logic [NP*BA-1:0] rd_adr = '0;
   logic [NP*W-1:0] rd_dout = '0;
   logic o_err_any, o_cmd_err, o_refr_err;
   logic [NP-1:0] o_data_err, o_vld_err;
   logic [CW-1:0] o_derr_cnt, o_err_cnt;
   logic [1:0] o_first_port;
   logic [BA-1:0] o_first_adr;

   always #5 clk = ~clk;

   algo_nror1w_rdchk #(.NUMRDPT(NP), .WIDTH(W), .NUMADDR(8192), .BITADDR(BA), .DELAY(DL),
                       .REFRESH(1), .REFFREQ(RF), .ERRCNTW(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_ready(ready), .i_refr(refr), .i_write(write),
      .i_wr_adr(wr_adr), .i_din(din), .i_read(read), .i_rd_adr(rd_adr), .i_rd_vld(rd_vld),
      .i_rd_dout(rd_dout), .i_rd_serr(rd_serr), .i_rd_derr(rd_derr),
      .o_err_any(o_err_any), .o_data_err(o_data_err), .o_vld_err(o_vld_err),
      .o_cmd_err(o_cmd_err), .o_refr_err(o_refr_err), .o_derr_cnt(o_derr_cnt),
      .o_err_cnt(o_err_cnt), .o_first_port(o_first_port), .o_first_adr(o_first_adr));

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: outstanding reads are stamped with the cycle their response is due.
   typedef struct {
      int             due;
      int             port;
      bit             known;
      logic [W-1:0]   exp;
      int             adr;
   } rd_t;
   rd_t pq[$];
   logic [W-1:0] sh[int];
   int m_cyc = 0, m_since = 0, m_err_cnt = 0, m_derr_cnt = 0, m_first_port = 0, m_first_adr = 0;
   bit m_err_any = 1'b0, m_refr_err = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         logic [NP-1:0] e_dat, e_vld, iss, pe;
         bit e_cmd, viol, cmdany;
         int pop, dpop, a;
         int radr[NP];
         rd_t r;
         cmp("err_cnt", o_err_cnt, 64'(m_err_cnt));
         cmp("derr_cnt", o_derr_cnt, 64'(m_derr_cnt));
         cmp("err_any", o_err_any, 64'(m_err_any));
         cmp("refr_err", o_refr_err, 64'(m_refr_err));
         cmp("first_port", o_first_port, 64'(m_first_port));
         cmp("first_adr", o_first_adr, 64'(m_first_adr));
         e_dat = '0; e_vld = '0; iss = '0; e_cmd = 1'b0; viol = 1'b0;
         for (int p = 0; p < NP; p++) radr[p] = 0;
         cmdany = write || (read != 0);
         if (!rst) begin
            while (pq.size() > 0 && pq[0].due == m_cyc) begin
               r = pq.pop_front();
               iss[r.port] = 1'b1;
               radr[r.port] = r.adr;
               if (rd_vld[r.port] && r.known && !rd_derr[r.port] &&
                   rd_dout[r.port*W +: W] != r.exp) e_dat[r.port] = 1'b1;
            end
            e_vld = iss ^ rd_vld;
            e_cmd = (write && read != 0) || (cmdany && !ready) || (refr && cmdany);
            viol  = (m_since >= RF) && !refr;
         end
         cmp("data_err", o_data_err, e_dat);
         cmp("vld_err", o_vld_err, e_vld);
         cmp("cmd_err", o_cmd_err, e_cmd);
         if (rst) begin
            pq.delete(); sh.delete();
            m_since = 0; m_err_cnt = 0; m_derr_cnt = 0; m_err_any = 0; m_refr_err = 0;
            m_first_port = 0; m_first_adr = 0;
         end else begin
            pe   = e_dat | e_vld;
            pop  = $countones(pe);
            dpop = $countones(rd_vld & rd_derr);
            m_err_cnt  = (m_err_cnt + pop > SAT) ? SAT : m_err_cnt + pop;
            m_derr_cnt = (m_derr_cnt + dpop > SAT) ? SAT : m_derr_cnt + dpop;
            if (pe != 0 && !m_err_any) begin
               for (int p = NP - 1; p >= 0; p--)
                  if (pe[p]) begin m_first_port = p; m_first_adr = radr[p]; end
            end
            if (pe != 0 || e_cmd || viol) m_err_any = 1'b1;
            if (viol) m_refr_err = 1'b1;
            if (refr) m_since = 0; else if (ready) m_since++;
            for (int p = 0; p < NP; p++) begin
               if (read[p] && ready) begin
                  a = int'(rd_adr[p*BA +: BA]);
                  r.due = m_cyc + DL; r.port = p; r.adr = a;
                  r.known = sh.exists(a);
                  r.exp = r.known ? sh[a] : '0;
                  pq.push_back(r);
               end
            end
            if (write && ready) sh[int'(wr_adr)] = din;
         end
         m_cyc++;
      end
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic idle(); write = 0; read = '0; refr = 0; rd_vld = '0; rd_derr = '0; rd_serr = '0; endtask
   task automatic wr(input int a, input logic [W-1:0] d);
      idle(); ready = 1; write = 1; wr_adr = BA'(a); din = d; step(); write = 0;
   endtask
   task automatic rd(input int p, input int a);
      idle(); ready = 1; read[p] = 1'b1; rd_adr[p*BA +: BA] = BA'(a); step(); read = '0;
   endtask
   task automatic refr_cyc(); idle(); ready = 1; refr = 1; step(); refr = 0; endtask
   task automatic wait1(); idle(); ready = 1; step(); endtask
   task automatic resp(input logic [NP-1:0] v, input int p, input logic [W-1:0] d);
      idle(); ready = 1; rd_vld = v; rd_dout[p*W +: W] = d; #1;
   endtask

   logic [NP-1:0] sv[4];
   logic [NP*W-1:0] sd[4];
   logic [W-1:0] tmem[int];
   int dcyc = 0;

   initial begin
      idle(); rst = 1; ready = 0;
      step(); chk_en = 1; step(); rst = 0;
      cmp("rst_err_any", o_err_any, 0);
      cmp("rst_err_cnt", o_err_cnt, 0);
      cmp("rst_refr_err", o_refr_err, 0);

      // Clean write then read on port 2
      refr_cyc(); wr(5, 64'hA5A5); wait1(); rd(2, 5); wait1();
      resp(4'b0100, 2, 64'hA5A5);
      cmp("t1_data_err", o_data_err, 0); cmp("t1_vld_err", o_vld_err, 0); step();
      cmp("t1_err_cnt", o_err_cnt, 0); cmp("t1_err_any", o_err_any, 0);

      // Single-bit mismatch on port 2
      refr_cyc(); rd(2, 5); wait1();
      resp(4'b0100, 2, 64'hA5A4);
      cmp("t2_data_err", o_data_err, 4'b0100); cmp("t2_err_any_pre", o_err_any, 0); step();
      cmp("t2_err_cnt", o_err_cnt, 1); cmp("t2_first_port", o_first_port, 2);
      cmp("t2_first_adr", o_first_adr, 5); cmp("t2_err_any", o_err_any, 1);
      cmp("t2_model_cnt", 64'(m_err_cnt), 1); cmp("t2_model_port", 64'(m_first_port), 2);

      // Two ports erring together, then a later error elsewhere
      idle(); rst = 1; step(); rst = 0;
      refr_cyc(); wr(5, 64'h1111); wr(9, 64'h2222);
      idle(); ready = 1; read = 4'b1001; rd_adr[0 +: BA] = 5; rd_adr[3*BA +: BA] = 9; step();
      wait1();
      resp(4'b1001, 0, 64'h1110); rd_dout[3*W +: W] = 64'h2223; #1;
      cmp("t3_data_err", o_data_err, 4'b1001); step();
      cmp("t3_err_cnt", o_err_cnt, 2); cmp("t3_first_port", o_first_port, 0);
      cmp("t3_first_adr", o_first_adr, 5);
      refr_cyc(); rd(1, 9); wait1();
      resp(4'b0010, 1, 64'h0);
      cmp("t3b_data_err", o_data_err, 4'b0010); step();
      cmp("t3b_err_cnt", o_err_cnt, 3); cmp("t3b_first_port", o_first_port, 0);

      // Spurious and missing valids
      refr_cyc();
      resp(4'b0010, 1, 64'h0);
      cmp("t4_spurious", o_vld_err, 4'b0010); step();
      rd(0, 5); wait1();
      resp(4'b0000, 0, 64'h0);
      cmp("t4_missing", o_vld_err, 4'b0001); step();
      cmp("t4_err_cnt", o_err_cnt, 5);

      // Illegal command mixes; a same-cycle read sees the pre-write data
      refr_cyc(); wr(7, 64'h1234);
      idle(); ready = 1; write = 1; wr_adr = 7; din = 64'hBEEF; read = 4'b0001; rd_adr[0 +: BA] = 7; #1;
      cmp("t5_cmd_wr_rd", o_cmd_err, 1); step();
      idle(); #1; cmp("t5_cmd_clear", o_cmd_err, 0); step();
      resp(4'b0001, 0, 64'h1234);
      cmp("t5_old_data", o_data_err, 0); cmp("t5_old_vld", o_vld_err, 0); step();
      idle(); ready = 0; write = 1; wr_adr = 3; din = 64'h1; #1;
      cmp("t5_cmd_notready", o_cmd_err, 1); step();
      refr_cyc(); rd(0, 7); wait1();
      resp(4'b0001, 0, 64'hBEEF);
      cmp("t5_new_data", o_data_err, 0); step();
      rd(0, 3); wait1();
      resp(4'b0001, 0, 64'hDEAD);
      cmp("t5_unknown", o_data_err, 0); cmp("t5_unknown_vld", o_vld_err, 0); step();

      // Refresh cadence, then counter saturation
      idle(); rst = 1; ready = 1; step(); rst = 0;
      refr_cyc();
      for (int i = 1; i <= 9; i++) begin
         wait1();
         cmp("t6_refr_err", o_refr_err, 64'(i >= 7));
      end
      idle(); ready = 1; rd_vld = 4'b1111; rd_derr = 4'b1111;
      repeat (16400) step();
      cmp("t6_err_sat", o_err_cnt, 16'hFFFF); cmp("t6_derr_sat", o_derr_cnt, 16'hFFFF);
      cmp("t6_model_sat", 64'(m_err_cnt), 16'hFFFF); cmp("t6_refr_sticky", o_refr_err, 1);
      rst = 1; #1;
      cmp("t6_rst_vld_gate", o_vld_err, 0); step();
      cmp("t6_rst_err_cnt", o_err_cnt, 0); cmp("t6_rst_derr_cnt", o_derr_cnt, 0);
      cmp("t6_rst_err_any", o_err_any, 0); cmp("t6_rst_refr_err", o_refr_err, 0);
      cmp("t6_rst_first_adr", o_first_adr, 0);
      idle(); step(); rst = 0;

      // Random traffic with a well-behaved memory plus injected faults
      for (int i = 0; i < 4; i++) begin sv[i] = '0; sd[i] = '0; end
      for (int n = 0; n < 3000; n++) begin
         int s, s2, a, m;
         logic [W-1:0] d;
         rst   = ($urandom_range(299) == 0);
         ready = ($urandom_range(7) != 0);
         refr  = ($urandom_range(4) == 0);
         m     = $urandom_range(9);
         write = (m < 4) || (m == 8);
         read  = (m >= 4 && m <= 8) ? 4'($urandom_range(15)) : 4'b0;
         wr_adr = BA'($urandom_range(15));
         din    = {$urandom, $urandom};
         for (int p = 0; p < NP; p++) rd_adr[p*BA +: BA] = BA'($urandom_range(15));
         s = dcyc % 4;
         rd_vld = sv[s]; rd_dout = sd[s]; sv[s] = '0;
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(19) == 0) begin
               a = p * W + int'($urandom_range(63));
               rd_dout[a] = ~rd_dout[a];
            end
            if ($urandom_range(29) == 0) rd_vld[p] = ~rd_vld[p];
            rd_derr[p] = ($urandom_range(19) == 0);
            rd_serr[p] = ($urandom_range(9) == 0);
         end
         if (!rst && ready) begin
            s2 = (dcyc + DL) % 4;
            for (int p = 0; p < NP; p++) begin
               if (read[p]) begin
                  a = int'(rd_adr[p*BA +: BA]);
                  d = tmem.exists(a) ? tmem[a] : {$urandom, $urandom};
                  sv[s2][p] = 1'b1;
                  sd[s2][p*W +: W] = d;
               end
            end
            if (write) tmem[int'(wr_adr)] = din;
         end
         step();
         dcyc++;
      end
      idle(); rst = 0; ready = 1;
      repeat (4) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
